cim_sched: RTL and testbench

- Sequencer and arbiter between the RV32 core's CIM instruction port, a weight-loader master, and the single CIM macro.
- Converts each single-cycle CIM request into a timed macro operation with a per-op latency.
- Stalls the core through HLT until the operation completes and returns read data.
- Sits between darkriscv CIM outputs and the macro in the SoC top.

---
 rtl/cim_sched_if.sv | 54 +++++
 rtl/cim_sched.sv | 211 +++++++++++++++++++++
 tb/tb_cim_sched.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_sched_if.sv
// rtl/cim_sched_if.sv - signal bundle between core, weight loader, cim_sched and the CIM macro
// Purpose: groups the core instruction port, loader write port and macro port of cim_sched.
// Ports (signals):
//   core_req/core_op/core_addr/core_wdata/core_oreg  core CIM instruction (master -> scheduler)
//   core_hlt/core_rdata                             stall and read result (scheduler -> master)
//   ld_req/ld_addr/ld_wdata                         loader write request (master -> scheduler)
//   ld_gnt                                          loader accept pulse (scheduler -> master)
//   m_write/m_cim/m_partial_sum/m_reset_output      macro strobes (scheduler -> macro)
//   m_output_reg/m_address/m_input_data             macro select/address/data (scheduler -> macro)
//   m_rdata                                         macro read data (macro -> scheduler)
// Modports: slave = scheduler side, master = core/loader/macro environment side.
interface cim_sched_if;
    logic        core_req;
    logic [2:0]  core_op;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_oreg;
    logic        core_hlt;
    logic [31:0] core_rdata;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;

    logic        m_write;
    logic        m_cim;
    logic        m_partial_sum;
    logic        m_reset_output;
    logic [3:0]  m_output_reg;
    logic [31:0] m_address;
    logic [31:0] m_input_data;
    logic [31:0] m_rdata;

    modport slave (
        input  core_req, core_op, core_addr, core_wdata, core_oreg,
        output core_hlt, core_rdata,
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        output m_write, m_cim, m_partial_sum, m_reset_output,
        output m_output_reg, m_address, m_input_data,
        input  m_rdata
    );

    modport master (
        output core_req, core_op, core_addr, core_wdata, core_oreg,
        input  core_hlt, core_rdata,
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        input  m_write, m_cim, m_partial_sum, m_reset_output,
        input  m_output_reg, m_address, m_input_data,
        output m_rdata
    );
endinterface

// File: rtl/cim_sched.sv
// rtl/cim_sched.sv - CIM instruction sequencer and core/loader arbiter for a single CIM macro
// Purpose: turns single-cycle core CIM requests and loader writes into timed macro operations,
//          stalling the core through core_hlt until its operation completes.
// Optional feature macro: CIM_SCHED_STATS_EN (adds stat_clr, stat_comp_cnt, stat_stall_cnt).
// Ports:
//   CLK             clock
//   RES             asynchronous reset, active-low
//   stat_clr        synchronous statistics clear (CIM_SCHED_STATS_EN only)
//   stat_comp_cnt   COMP grants counted (CIM_SCHED_STATS_EN only)
//   stat_stall_cnt  cycles with core_hlt=1 (CIM_SCHED_STATS_EN only)
//   bus             cim_sched_if.slave: core port, loader port, macro port
module cim_sched #(
    parameter int unsigned WR_LAT       = 1,
    parameter int unsigned COMP_LAT     = 4,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned LD_MAX_BURST = 8
) (
    input  logic        CLK,
    input  logic        RES,
`ifdef CIM_SCHED_STATS_EN
    input  logic        stat_clr,
    output logic [31:0] stat_comp_cnt,
    output logic [31:0] stat_stall_cnt,
`endif
    cim_sched_if.slave  bus
);
    localparam logic [2:0] OP_WR     = 3'd0;
    localparam logic [2:0] OP_COMP   = 3'd1;
    localparam logic [2:0] OP_RD     = 3'd2;
    localparam logic [2:0] OP_REG_RD = 3'd3;
    localparam logic [2:0] OP_REG_RS = 3'd4;

    localparam logic [3:0] L_WR    = 4'(WR_LAT);
    localparam logic [3:0] L_COMP  = 4'(COMP_LAT);
    localparam logic [3:0] L_RD    = 4'(RD_LAT);
    localparam logic [7:0] L_BURST = 8'(LD_MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_owner_ld;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_oreg;
    logic [3:0]  r_cnt;
    logic [7:0]  r_burst;
    logic [31:0] r_rdata;

    logic        w_ld_win;
    logic        w_grant;
    logic        w_ld_grant;
    logic        w_core_grant;
    logic        w_last;
    logic        w_core_hlt;
    logic [2:0]  w_issue_op;
    logic [3:0]  w_issue_lat;

    // Loader is preferred until it has taken L_BURST grants in front of a waiting core.
    // With no core request pending the loader always wins.
    assign w_ld_win     = bus.ld_req && (!bus.core_req || (r_burst < L_BURST));
    assign w_grant      = (r_state == S_IDLE) && (bus.core_req || bus.ld_req);
    assign w_ld_grant   = w_grant && w_ld_win;
    assign w_core_grant = w_grant && !w_ld_win;
    assign w_issue_op   = w_ld_win ? OP_WR : bus.core_op;
    assign w_last       = (r_state == S_BUSY) && (r_cnt <= 4'd1);

    always_comb begin
        w_issue_lat = 4'd1;
        case (w_issue_op)
            OP_WR:     w_issue_lat = L_WR;
            OP_COMP:   w_issue_lat = L_COMP;
            OP_RD:     w_issue_lat = L_RD;
            OP_REG_RD: w_issue_lat = L_RD;
            default:   w_issue_lat = 4'd1;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next_state = S_BUSY;
            S_BUSY:  if (w_last)  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Issue registers, latency counter and read-data capture
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_owner_ld <= 1'b0;
            r_op       <= 3'd0;
            r_addr     <= 32'd0;
            r_data     <= 32'd0;
            r_oreg     <= 4'd0;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'd0;
        end else begin
            if (w_grant) begin
                r_owner_ld <= w_ld_win;
                r_op       <= w_issue_op;
                r_addr     <= w_ld_win ? bus.ld_addr  : bus.core_addr;
                r_data     <= w_ld_win ? bus.ld_wdata : bus.core_wdata;
                r_oreg     <= w_ld_win ? 4'd0         : bus.core_oreg;
                r_cnt      <= w_issue_lat;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
                if (w_last && !r_owner_ld) begin
                    case (r_op)
                        OP_RD, OP_REG_RD:           r_rdata <= bus.m_rdata;
                        OP_WR, OP_COMP, OP_REG_RS:  r_rdata <= r_rdata;
                        default:                    r_rdata <= 32'd0;
                    endcase
                end
            end
        end
    end

    // Loader burst counter: only meaningful while the core is waiting
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_burst <= 8'd0;
        end else if (!bus.core_req || w_core_grant) begin
            r_burst <= 8'd0;
        end else if (w_ld_grant && (r_burst != 8'hFF)) begin
            r_burst <= r_burst + 8'd1;
        end
    end

    // Output logic
    assign w_core_hlt = bus.core_req && !((r_state == S_DONE) && !r_owner_ld);

    always_comb begin
        bus.m_write        = 1'b0;
        bus.m_cim          = 1'b0;
        bus.m_partial_sum  = 1'b0;
        bus.m_reset_output = 1'b0;
        bus.m_output_reg   = 4'd0;
        bus.m_address      = 32'd0;
        bus.m_input_data   = 32'd0;
        if (r_state == S_BUSY) begin
            case (r_op)
                OP_WR: begin
                    bus.m_write      = 1'b1;
                    bus.m_address    = r_addr;
                    bus.m_input_data = r_data;
                end
                OP_COMP: begin
                    bus.m_cim         = 1'b1;
                    bus.m_partial_sum = 1'b1;
                    bus.m_address     = r_addr;
                    bus.m_input_data  = r_data;
                end
                OP_RD: begin
                    bus.m_address = r_addr;
                end
                OP_REG_RD: begin
                    bus.m_cim        = 1'b1;
                    bus.m_output_reg = r_oreg;
                end
                OP_REG_RS: begin
                    bus.m_cim          = 1'b1;
                    bus.m_reset_output = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.core_hlt   = w_core_hlt;
    assign bus.core_rdata = r_rdata;
    // No grant is taken while reset is held, so the pulse is suppressed too.
    assign bus.ld_gnt     = w_ld_grant && RES;

`ifdef CIM_SCHED_STATS_EN
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            stat_comp_cnt  <= 32'd0;
            stat_stall_cnt <= 32'd0;
        end else if (stat_clr) begin
            stat_comp_cnt  <= 32'd0;
            stat_stall_cnt <= 32'd0;
        end else begin
            if (w_core_grant && (bus.core_op == OP_COMP)) begin
                stat_comp_cnt <= stat_comp_cnt + 32'd1;
            end
            if (w_core_hlt) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cim_sched.sv
// tb/tb_cim_sched.sv - directed self-checking bench for cim_sched
module tb_cim_sched;
    logic CLK;
    logic RES;
    int   errors;
    int   checks;

    cim_sched_if bus ();

`ifdef CIM_SCHED_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_comp_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    cim_sched #(
        .WR_LAT       (1),
        .COMP_LAT     (4),
        .RD_LAT       (2),
        .LD_MAX_BURST (2)
    ) dut (
        .CLK            (CLK),
        .RES            (RES),
`ifdef CIM_SCHED_STATS_EN
        .stat_clr       (stat_clr),
        .stat_comp_cnt  (stat_comp_cnt),
        .stat_stall_cnt (stat_stall_cnt),
`endif
        .bus            (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [107:0] macro_bus();
        return {bus.m_write, bus.m_cim, bus.m_partial_sum, bus.m_reset_output,
                bus.m_output_reg, bus.m_address, bus.m_input_data, 32'd0};
    endfunction

    // Runs one core instruction from IDLE and reports what was seen on the macro port.
    // Macro read data is only valid in cycle 'lat' (the last BUSY cycle).
    task automatic core_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] oreg, input int lat, input logic [31:0] rd_val,
                           output int n_hlt, output int n_wr, output int n_cim, output int n_ps,
                           output int n_rst, output logic [31:0] seen_addr,
                           output logic [31:0] seen_data, output logic [3:0] seen_oreg,
                           output logic [31:0] rdata_done, output logic macro_at_done);
        n_hlt = 0; n_wr = 0; n_cim = 0; n_ps = 0; n_rst = 0;
        seen_addr = 32'd0; seen_data = 32'd0; seen_oreg = 4'd0;
        rdata_done = 32'hFFFF_FFFF; macro_at_done = 1'b1;
        bus.core_req = 1'b1; bus.core_op = op; bus.core_addr = addr;
        bus.core_wdata = data; bus.core_oreg = oreg;
        for (int c = 0; c < 40; c++) begin
            bus.m_rdata = (c == lat) ? rd_val : 32'hDEAD_0000;
            #1;
            if (!bus.core_hlt) begin
                rdata_done    = bus.core_rdata;
                macro_at_done = |macro_bus();
                break;
            end
            n_hlt++;
            if (bus.m_write)        n_wr++;
            if (bus.m_cim)          n_cim++;
            if (bus.m_partial_sum)  n_ps++;
            if (bus.m_reset_output) n_rst++;
            if (c == 1) begin
                seen_addr = bus.m_address;
                seen_data = bus.m_input_data;
                seen_oreg = bus.m_output_reg;
            end
            tick();
        end
        tick();
        bus.core_req = 1'b0;
        bus.m_rdata  = 32'd0;
        #1;
    endtask

    task automatic test_reset();
        RES = 1'b0;
        bus.core_req = 1'b1; bus.core_op = 3'd1; bus.core_addr = 32'h1;
        bus.core_wdata = 32'h2; bus.core_oreg = 4'd1;
        bus.ld_req = 1'b1; bus.ld_addr = 32'h3; bus.ld_wdata = 32'h4; bus.m_rdata = 32'h5;
        tick(); tick();
        checks++;
        if (bus.core_hlt !== 1'b1) begin
            errors++; $display("FAIL reset_hlt: got %b want 1", bus.core_hlt);
        end
        checks++;
        if (bus.ld_gnt !== 1'b0) begin
            errors++; $display("FAIL reset_ld_gnt: got %b want 0", bus.ld_gnt);
        end
        checks++;
        if (macro_bus() !== 108'd0) begin
            errors++; $display("FAIL reset_macro: got %h want 0", macro_bus());
        end
        checks++;
        if (bus.core_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", bus.core_rdata);
        end
        bus.core_req = 1'b0; bus.ld_req = 1'b0; bus.m_rdata = 32'd0;
        #1;
        checks++;
        if (bus.core_hlt !== 1'b0) begin
            errors++; $display("FAIL reset_hlt_idle: got %b want 0", bus.core_hlt);
        end
        RES = 1'b1;
        tick();
    endtask

    task automatic test_wr();
        int n_hlt, n_wr, n_cim, n_ps, n_rst;
        logic [31:0] sa, sd, rd; logic [3:0] so; logic md;
        core_op(3'd0, 32'h10, 32'hA5A5_A5A5, 4'd0, 1, 32'd0,
                n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        checks++;
        if (n_hlt !== 2 || n_wr !== 1 || n_cim !== 0) begin
            errors++; $display("FAIL wr_timing: got hlt=%0d wr=%0d cim=%0d want 2 1 0", n_hlt, n_wr, n_cim);
        end
        checks++;
        if (sa !== 32'h10 || sd !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL wr_bus: got addr=%h data=%h want 10 a5a5a5a5", sa, sd);
        end
        checks++;
        if (md !== 1'b0) begin
            errors++; $display("FAIL wr_done_quiet: got %b want 0", md);
        end
    endtask

    task automatic test_comp();
        int n_hlt, n_wr, n_cim, n_ps, n_rst;
        logic [31:0] sa, sd, rd; logic [3:0] so; logic md;
        core_op(3'd1, 32'h20, 32'h0F0F_1234, 4'd0, 4, 32'd0,
                n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        checks++;
        if (n_hlt !== 5 || n_cim !== 4 || n_ps !== 4 || n_wr !== 0) begin
            errors++; $display("FAIL comp_timing: got hlt=%0d cim=%0d ps=%0d wr=%0d want 5 4 4 0",
                               n_hlt, n_cim, n_ps, n_wr);
        end
        checks++;
        if (sa !== 32'h20 || sd !== 32'h0F0F_1234) begin
            errors++; $display("FAIL comp_bus: got addr=%h data=%h want 20 0f0f1234", sa, sd);
        end
    endtask

    task automatic test_reg_rd();
        int n_hlt, n_wr, n_cim, n_ps, n_rst;
        logic [31:0] sa, sd, rd; logic [3:0] so; logic md;
        core_op(3'd3, 32'd0, 32'd0, 4'd3, 2, 32'h1234_5678,
                n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        checks++;
        if (n_hlt !== 3 || n_cim !== 2 || n_ps !== 0 || so !== 4'd3) begin
            errors++; $display("FAIL regrd_bus: got hlt=%0d cim=%0d ps=%0d oreg=%0d want 3 2 0 3",
                               n_hlt, n_cim, n_ps, so);
        end
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL regrd_data: got %h want 12345678", rd);
        end
    endtask

    task automatic test_rd_and_illegal();
        int n_hlt, n_wr, n_cim, n_ps, n_rst;
        logic [31:0] sa, sd, rd; logic [3:0] so; logic md;
        core_op(3'd2, 32'h40, 32'd0, 4'd0, 2, 32'hCAFE_BABE,
                n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        checks++;
        if (n_hlt !== 3 || (n_wr + n_cim) !== 0 || sa !== 32'h40 || rd !== 32'hCAFE_BABE) begin
            errors++; $display("FAIL rd: got hlt=%0d strobes=%0d addr=%h data=%h want 3 0 40 cafebabe",
                               n_hlt, n_wr + n_cim, sa, rd);
        end
        core_op(3'd4, 32'd0, 32'd0, 4'd0, 1, 32'd0,
                n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        checks++;
        if (n_hlt !== 2 || n_rst !== 1 || n_cim !== 1 || n_ps !== 0) begin
            errors++; $display("FAIL regreset: got hlt=%0d rst=%0d cim=%0d ps=%0d want 2 1 1 0",
                               n_hlt, n_rst, n_cim, n_ps);
        end
        core_op(3'd6, 32'h77, 32'h88, 4'd2, 1, 32'h9999_9999,
                n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        checks++;
        if (n_hlt !== 2 || (n_wr + n_cim + n_ps + n_rst) !== 0) begin
            errors++; $display("FAIL illegal_op: got hlt=%0d strobes=%0d want 2 0",
                               n_hlt, n_wr + n_cim + n_ps + n_rst);
        end
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL illegal_rdata: got %h want 0", rd);
        end
    endtask

    task automatic test_loader_burst();
        int gnt_cyc[4];
        int n_gnt;
        int done_cyc;
        logic ld_wr_ok;
        n_gnt = 0; done_cyc = -1; ld_wr_ok = 1'b0;
        bus.ld_req = 1'b1; bus.ld_addr = 32'h100; bus.ld_wdata = 32'h11;
        bus.core_req = 1'b1; bus.core_op = 3'd0; bus.core_addr = 32'h200;
        bus.core_wdata = 32'h22; bus.core_oreg = 4'd0;
        for (int c = 0; c < 13; c++) begin
            if (c == 9)  bus.core_req = 1'b0;
            if (c == 10) bus.ld_req = 1'b0;
            #1;
            if (bus.ld_gnt) begin
                if (n_gnt < 4) gnt_cyc[n_gnt] = c;
                n_gnt++;
            end
            if (bus.core_req && !bus.core_hlt && done_cyc < 0) done_cyc = c;
            if (c == 1) ld_wr_ok = bus.m_write && (bus.m_address == 32'h100) && (bus.m_input_data == 32'h11);
            tick();
        end
        checks++;
        if (n_gnt !== 3) begin
            errors++; $display("FAIL burst_gnt_count: got %0d want 3", n_gnt);
        end else begin
            checks++;
            if (gnt_cyc[0] !== 0 || gnt_cyc[1] !== 3 || gnt_cyc[2] !== 9) begin
                errors++; $display("FAIL burst_gnt_cycles: got %0d %0d %0d want 0 3 9",
                                   gnt_cyc[0], gnt_cyc[1], gnt_cyc[2]);
            end
        end
        checks++;
        if (done_cyc !== 8) begin
            errors++; $display("FAIL burst_core_done: got cycle %0d want 8", done_cyc);
        end
        checks++;
        if (ld_wr_ok !== 1'b1) begin
            errors++; $display("FAIL burst_ld_write: got %b want 1", ld_wr_ok);
        end
    endtask

    task automatic test_reset_abort();
        int n_hlt, n_wr, n_cim, n_ps, n_rst;
        logic [31:0] sa, sd, rd; logic [3:0] so; logic md;
        logic cim_before;
        bus.core_req = 1'b1; bus.core_op = 3'd1; bus.core_addr = 32'h55; bus.core_wdata = 32'h66;
        tick(); tick();
        #1;
        cim_before = bus.m_cim;
        RES = 1'b0;
        #1;
        checks++;
        if (cim_before !== 1'b1) begin
            errors++; $display("FAIL abort_busy: got m_cim=%b want 1", cim_before);
        end
        checks++;
        if (macro_bus() !== 108'd0 || bus.core_hlt !== 1'b1) begin
            errors++; $display("FAIL abort_drop: got macro=%h hlt=%b want 0 1", macro_bus(), bus.core_hlt);
        end
        tick();
        RES = 1'b1;
        core_op(3'd1, 32'h55, 32'h66, 4'd0, 4, 32'd0,
                n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        checks++;
        if (n_hlt !== 5 || n_cim !== 4 || sa !== 32'h55) begin
            errors++; $display("FAIL abort_regrant: got hlt=%0d cim=%0d addr=%h want 5 4 55", n_hlt, n_cim, sa);
        end
    endtask

`ifdef CIM_SCHED_STATS_EN
    task automatic test_stats();
        int n_hlt, n_wr, n_cim, n_ps, n_rst;
        logic [31:0] sa, sd, rd; logic [3:0] so; logic md;
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            core_op(3'd1, 32'h30 + 32'(k), 32'h1, 4'd0, 4, 32'd0,
                    n_hlt, n_wr, n_cim, n_ps, n_rst, sa, sd, so, rd, md);
        end
        checks++;
        if (stat_comp_cnt !== 32'd3 || stat_stall_cnt !== 32'd15) begin
            errors++; $display("FAIL stats_count: got comp=%0d stall=%0d want 3 15", stat_comp_cnt, stat_stall_cnt);
        end
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        checks++;
        if (stat_comp_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL stats_clear: got comp=%0d stall=%0d want 0 0", stat_comp_cnt, stat_stall_cnt);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
`ifdef CIM_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_wr();
        test_comp();
        test_reg_rd();
        test_rd_and_illegal();
        test_loader_burst();
        test_reset_abort();
`ifdef CIM_SCHED_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
